// File: rtl/anim_draw_sequencer.sv
// anim_draw_sequencer
//   Turns the pet's mood code into a two-frame animation for the downstream
//   PCD8544 sprite SPI driver. Each sprite code is presented on `draw` with a
//   one-cycle `draw_valid` strobe. The code is never changed until the driver
//   reports `draw_done`. After that, the frame is held for FRAME_CYCLES before
//   the next code is issued.
//
// Ports
//   clock        system clock, rising edge
//   Reset        synchronous, active-high reset
//   pet_state    [2:0] mood code (0..4 valid, 5..7 shown as sprite 0xF)
//   draw_done    one-cycle completion pulse from the SPI driver
//   draw         [3:0] sprite code = {mood, frame}, or 0xF for invalid moods
//   draw_valid   one-cycle strobe marking a new request on `draw`
//   seq_busy     high while a request is outstanding
//   timeout_err  sticky re-issue-after-timeout flag
//
// Build option
//   DRAW_TIMEOUT_EN  when defined, a request that sees no draw_done within
//                    TIMEOUT_CYCLES is re-strobed with the same code and
//                    timeout_err is set. When undefined, timeout_err is tied
//                    low and the sequencer waits indefinitely.

module anim_draw_sequencer #(
  parameter int unsigned FRAME_CYCLES   = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned CNT_W          = 25
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [2:0] pet_state,
  input  logic       draw_done,
  output logic [3:0] draw,
  output logic       draw_valid,
  output logic       seq_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  // Elaboration-time guard: the shared counter must reach both terminal counts.
  if (FRAME_CYCLES < 32'd2 ||
      ((FRAME_CYCLES - 32'd1) >> CNT_W) != 32'd0 ||
      ((TIMEOUT_CYCLES - 32'd1) >> CNT_W) != 32'd0) begin : g_bad_params
    $error("anim_draw_sequencer: FRAME_CYCLES/TIMEOUT_CYCLES do not fit CNT_W");
  end

  function automatic logic [3:0] sprite_code(input logic [2:0] mood, input logic frm);
    return (mood <= 3'd4) ? {mood, frm} : 4'hF;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       draw_q, draw_d;
  logic             draw_valid_q;
  logic             seq_busy_q;

`ifdef DRAW_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    draw_d  = draw_q;
`ifdef DRAW_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cur_d   = pet_state;
        frame_d = 1'b0;
        draw_d  = sprite_code(pet_state, 1'b0);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (draw_done) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
`ifdef DRAW_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          // Re-issue the unchanged code; draw_d keeps its value.
          timeout_err_d = 1'b1;
          state_d       = S_ISSUE;
        end
`endif
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      S_HOLD: begin
        if (cnt_q == HoldLast) begin
          // Mood is sampled only here; a new mood restarts at frame 0 and
          // invalid moods never animate.
          if (pet_state != cur_q) begin
            cur_d   = pet_state;
            frame_d = 1'b0;
          end else if (cur_q <= 3'd4) begin
            frame_d = ~frame_q;
          end
          draw_d  = sprite_code(cur_d, frame_d);
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  // Strobe and busy are registered from the next state so they line up with
  // the ISSUE/WAIT cycles without output decoding glitches.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      frame_q      <= 1'b0;
      cnt_q        <= '0;
      draw_q       <= '0;
      draw_valid_q <= 1'b0;
      seq_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      draw_q       <= draw_d;
      draw_valid_q <= (state_d == S_ISSUE);
      seq_busy_q   <= (state_d == S_ISSUE) || (state_d == S_WAIT);
    end
  end

`ifdef DRAW_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (Reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign draw       = draw_q;
  assign draw_valid = draw_valid_q;
  assign seq_busy   = seq_busy_q;

endmodule

// File: tb/tb_anim_draw_sequencer.sv
// Testbench for anim_draw_sequencer (FRAME_CYCLES=4, TIMEOUT_CYCLES=8, CNT_W=4).
// The reference model tracks events by absolute cycle number:
//   - when the next strobe is due,
//   - which request is outstanding,
//   - when the hold window ends.
// Every output is compared one time unit after each rising edge.
// It works with or without DRAW_TIMEOUT_EN defined.

module tb_anim_draw_sequencer;

  localparam int FRAME   = 4;
  localparam int TIMEOUT = 8;
`ifdef DRAW_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       Reset;
  logic [2:0] pet_state;
  logic       draw_done;
  logic [3:0] draw;
  logic       draw_valid;
  logic       seq_busy;
  logic       timeout_err;

  anim_draw_sequencer #(
    .FRAME_CYCLES  (FRAME),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (4)
  ) dut (
    .clock      (clock),
    .Reset      (Reset),
    .pet_state  (pet_state),
    .draw_done  (draw_done),
    .draw       (draw),
    .draw_valid (draw_valid),
    .seq_busy   (seq_busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int         cyc         = 0;   // index of the cycle whose inputs are being applied
  bit         m_idle      = 1'b1;
  bit         m_busy      = 1'b0;
  int         m_strobe_cyc = -100;
  int         m_hold_last = -1;
  logic [2:0] m_cur       = '0;
  bit         m_frame     = 1'b0;
  logic [3:0] m_code      = '0;
  bit         m_terr      = 1'b0;
  bit         e_valid     = 1'b0;
  logic [2:0] ps_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_code(input logic [2:0] mood, input bit frm);
    int c;
    if (mood > 3'd4) c = 15;
    else             c = 2 * int'(mood) + int'(frm);
    return 4'(c);
  endfunction

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_step(input logic rst, input logic [2:0] ps, input logic dd);
    int strobe_at = -1;
    if (rst) begin
      m_idle = 1'b1; m_busy = 1'b0; m_hold_last = -1;
      m_cur = '0; m_frame = 1'b0; m_code = '0; m_terr = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_cur = ps; m_frame = 1'b0;
      strobe_at = cyc + 1;
    end else if (m_busy && cyc > m_strobe_cyc) begin
      if (dd) begin
        m_busy      = 1'b0;
        m_hold_last = cyc + FRAME;
      end else if (TO_EN && cyc == m_strobe_cyc + TIMEOUT) begin
        strobe_at = cyc + 1;
        m_terr    = 1'b1;
      end
    end else if (cyc == m_hold_last) begin
      if (ps != m_cur) begin
        m_cur = ps; m_frame = 1'b0;
      end else if (m_cur <= 3'd4) begin
        m_frame = ~m_frame;
      end
      strobe_at   = cyc + 1;
      m_hold_last = -1;
    end
    cyc++;
    e_valid = (strobe_at == cyc);
    if (e_valid) begin
      m_strobe_cyc = cyc;
      m_busy       = 1'b1;
      m_code       = exp_code(m_cur, m_frame);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] ps, input logic dd);
    Reset     = rst;
    pet_state = ps;
    draw_done = dd;
    model_step(rst, ps, dd);
    @(posedge clock);
    #1;
    check_eq("draw",        32'(draw),        32'(m_code));
    check_eq("draw_valid",  32'(draw_valid),  32'(e_valid));
    check_eq("seq_busy",    32'(seq_busy),    32'(m_busy));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // mode 0: done `dly` cycles after each strobe
  // mode 1: done in the strobe cycle and again 3 cycles later
  // other modes: never send done
  task automatic run(input int n, input int mode, input int dly, input logic [2:0] ps);
    for (int i = 0; i < n; i++) begin
      logic dd;
      case (mode)
        0:       dd = m_busy && (cyc == m_strobe_cyc + dly);
        1:       dd = m_busy && (cyc == m_strobe_cyc || cyc == m_strobe_cyc + 3);
        default: dd = 1'b0;
      endcase
      step(1'b0, ps, dd);
    end
  endtask

  initial begin
    Reset = 1'b1; pet_state = 3'd1; draw_done = 1'b0;

    repeat (5) step(1'b1, 3'd1, 1'b0);
    run(24, 0, 3, 3'd1);            // 0x2, 0x3, 0x2 ...
    run(40, 0, 2, 3'd2);            // 0x4, 0x5, 0x4, 0x5

    // Move into a hold window with mood 1, then switch to mood 3 mid-hold.
    run(16, 0, 2, 3'd1);
    for (int i = 0; i < 20 && m_hold_last < 0; i++) run(1, 0, 2, 3'd1);
    run(1, 2, 0, 3'd1);
    run(24, 0, 2, 3'd3);            // next strobe carries 0x6

    run(30, 0, 2, 3'd6);            // invalid mood: always 0xF
    run(30, 1, 0, 3'd2);            // done coincident with the strobe is ignored
    run(30, 2, 0, 3'd0);            // no done: stall, or re-strobe every 9 cycles
    step(1'b1, 3'd0, 1'b0);         // reset while waiting
    step(1'b1, 3'd4, 1'b0);

    ps_r = 3'd1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ps_r = 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, ps_r, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
